cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between the arithmetic unit and the load/store unit.

---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-offer and broadcast signals shared between the two result sources,
// the CDB arbiter and the CDB consumers.
interface cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
);
  logic              alu_valid;
  logic [ROB_W-1:0]  alu_rob_id;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ready;
  logic              ls_valid;
  logic [ROB_W-1:0]  ls_rob_id;
  logic [DATA_W-1:0] ls_result;
  logic              ls_ready;
  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_rob_id;
  logic [DATA_W-1:0] cdb_result;
  logic              cdb_src;

  modport master (
    output alu_valid, alu_rob_id, alu_result, ls_valid, ls_rob_id, ls_result,
    input  alu_ready, ls_ready, cdb_valid, cdb_rob_id, cdb_result, cdb_src
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_result, ls_valid, ls_rob_id, ls_result,
    output alu_ready, ls_ready, cdb_valid, cdb_rob_id, cdb_result, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per result source (arith, load/store),
// round-robin pop of one entry per cycle onto a registered broadcast.
module cdb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ROB_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          misbranch_flag,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LS  = 1'b1;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_id;
    logic [DATA_W-1:0] result;
  } entry_t;

  entry_t           mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [CNT_W-1:0] count [2];
  logic             last_grant;

  entry_t in_entry [2];
  logic   in_valid [2];
  logic   src_ready [2];
  logic   not_empty [2];
  logic   push [2];
  logic   pop [2];
  logic   grant_valid;
  logic   grant_src;
  entry_t head;

  always_comb begin
    in_valid[SRC_ALU] = bus.alu_valid;
    in_entry[SRC_ALU] = '{rob_id: bus.alu_rob_id, result: bus.alu_result};
    in_valid[SRC_LS]  = bus.ls_valid;
    in_entry[SRC_LS]  = '{rob_id: bus.ls_rob_id, result: bus.ls_result};

    // Ready looks only at the registered count, so a full FIFO never accepts
    // even when it is being popped in the same cycle.
    for (int s = 0; s < 2; s++) begin
      src_ready[s] = rdy && (count[s] < FULL_CNT);
      not_empty[s] = (count[s] != '0);
      push[s]      = in_valid[s] && src_ready[s] && !misbranch_flag
                     && (in_entry[s].rob_id != '0);
    end

    grant_valid = not_empty[SRC_ALU] || not_empty[SRC_LS];
    grant_src   = (not_empty[SRC_ALU] && not_empty[SRC_LS]) ? ~last_grant
                                                            : not_empty[SRC_LS];

    for (int s = 0; s < 2; s++)
      pop[s] = rdy && !misbranch_flag && grant_valid && (grant_src == 1'(s));

    head = mem[grant_src][rd_ptr[grant_src]];
  end

  assign bus.alu_ready = src_ready[SRC_ALU];
  assign bus.ls_ready  = src_ready[SRC_LS];

  // NOTE: FIFO storage is not reset; count gates every read, so stale
  // contents are never observed and the array can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++)
      if (push[s]) mem[s][wr_ptr[s]] <= in_entry[s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else if (rdy) begin
      for (int s = 0; s < 2; s++) begin
        if (misbranch_flag) begin
          wr_ptr[s] <= '0;
          rd_ptr[s] <= '0;
          count[s]  <= '0;
        end else begin
          // Depth is a power of two, so pointer overflow is the wrap.
          if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
          if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
          count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
        end
      end
    end
  end

  // last_grant resets to load/store so the arith source wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cdb_valid  <= 1'b0;
      bus.cdb_rob_id <= '0;
      bus.cdb_result <= '0;
      bus.cdb_src    <= SRC_ALU;
      last_grant     <= SRC_LS;
    end else if (rdy) begin
      if (misbranch_flag) begin
        bus.cdb_valid <= 1'b0;
      end else if (grant_valid) begin
        bus.cdb_valid  <= 1'b1;
        bus.cdb_rob_id <= head.rob_id;
        bus.cdb_result <= head.result;
        bus.cdb_src    <= grant_src;
        last_grant     <= grant_src;
      end else begin
        bus.cdb_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue model predicts every edge, granted
// entries go to a scoreboard and are popped when the CDB shows a new broadcast.
module tb_cdb_arbiter;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [ROB_W-1:0]  id;
    logic [DATA_W-1:0] res;
  } entry_t;

  typedef struct packed {
    logic [ROB_W-1:0]  id;
    logic [DATA_W-1:0] res;
    logic              src;
  } bcast_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic misbranch_flag = 1'b0;

  cdb_arbiter_if #(.DATA_W(DATA_W), .ROB_W(ROB_W)) bus ();

  cdb_arbiter #(.DATA_W(DATA_W), .ROB_W(ROB_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .misbranch_flag (misbranch_flag),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  entry_t            m_qa[$];
  entry_t            m_ql[$];
  bcast_t            exp_q[$];
  logic [ROB_W-1:0]  obs_ids[$];
  logic              m_last, m_cv, m_csrc;
  logic [ROB_W-1:0]  m_cid;
  logic [DATA_W-1:0] m_cres;
  logic              alu_acc, ls_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_qa.delete();
    m_ql.delete();
    exp_q.delete();
    m_last = 1'b1;
    m_cv   = 1'b0;
    m_csrc = 1'b0;
    m_cid  = '0;
    m_cres = '0;
  endtask

  task automatic drive(input logic av, input logic [ROB_W-1:0] aid, input logic [DATA_W-1:0] ares,
                       input logic lv, input logic [ROB_W-1:0] lid, input logic [DATA_W-1:0] lres);
    bus.alu_valid  = av;
    bus.alu_rob_id = aid;
    bus.alu_result = ares;
    bus.ls_valid   = lv;
    bus.ls_rob_id  = lid;
    bus.ls_result  = lres;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // One clock edge: predict the edge from the model, then compare after it.
  task automatic tick();
    logic   rdy_e, ne_a, ne_l, src;
    entry_t e;
    bcast_t b;
    rdy_e   = rdy;
    alu_acc = 1'b0;
    ls_acc  = 1'b0;
    if (rdy) begin
      if (misbranch_flag) begin
        m_qa.delete();
        m_ql.delete();
        m_cv = 1'b0;
      end else begin
        alu_acc = bus.alu_valid && (m_qa.size() < DEPTH);
        ls_acc  = bus.ls_valid && (m_ql.size() < DEPTH);
        ne_a = (m_qa.size() != 0);
        ne_l = (m_ql.size() != 0);
        if (ne_a || ne_l) begin
          src = (ne_a && ne_l) ? ~m_last : ne_l;
          e = src ? m_ql.pop_front() : m_qa.pop_front();
          m_cv = 1'b1; m_cid = e.id; m_cres = e.res; m_csrc = src; m_last = src;
          exp_q.push_back('{id: e.id, res: e.res, src: src});
        end else begin
          m_cv = 1'b0;
        end
        if (alu_acc && bus.alu_rob_id != '0) m_qa.push_back('{id: bus.alu_rob_id, res: bus.alu_result});
        if (ls_acc && bus.ls_rob_id != '0)   m_ql.push_back('{id: bus.ls_rob_id, res: bus.ls_result});
      end
    end
    @(posedge clk);
    #1;
    if (rdy_e && bus.cdb_valid) begin
      obs_ids.push_back(bus.cdb_rob_id);
      check("bcast_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("sb_rob_id", 64'(bus.cdb_rob_id), 64'(b.id));
        check("sb_result", 64'(bus.cdb_result), 64'(b.res));
        check("sb_src", 64'(bus.cdb_src), 64'(b.src));
      end
    end
    check("cdb_valid", 64'(bus.cdb_valid), 64'(m_cv));
    check("cdb_rob_id_reg", 64'(bus.cdb_rob_id), 64'(m_cid));
    check("cdb_result_reg", 64'(bus.cdb_result), 64'(m_cres));
    check("alu_ready", 64'(bus.alu_ready), 64'(rdy && m_qa.size() < DEPTH));
    check("ls_ready", 64'(bus.ls_ready), 64'(rdy && m_ql.size() < DEPTH));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROB_W-1:0] exp_order [4];
    logic             zero_seen;
    exp_order = '{4'd1, 4'd5, 4'd2, 4'd6};
    drive_idle();
    reset_model();

    // Reset state
    #22;
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_cdb_rob_id", 64'(bus.cdb_rob_id), 64'd0);
    check("rst_cdb_result", 64'(bus.cdb_result), 64'd0);
    check("rst_cdb_src", 64'(bus.cdb_src), 64'd0);
    rst_n = 1'b1;
    rdy   = 1'b1;
    #1;
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("rst_ls_ready", 64'(bus.ls_ready), 64'd1);

    // Contention: arith wins the first tie, then strict alternation
    obs_ids.delete();
    drive(1'b1, 4'd1, 32'h101, 1'b1, 4'd5, 32'h505); tick();
    drive(1'b1, 4'd2, 32'h102, 1'b1, 4'd6, 32'h506); tick();
    drive_idle();
    repeat (4) tick();
    check("order_count", 64'(obs_ids.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < obs_ids.size()) check($sformatf("order_%0d", i), 64'(obs_ids[i]), 64'(exp_order[i]));

    // Full: LS FIFO fills while arith holds the bus, third push waits
    drive(1'b1, 4'd7, 32'h107, 1'b1, 4'd8, 32'h208); tick();
    drive(1'b1, 4'd9, 32'h109, 1'b1, 4'd10, 32'h20a); tick();
    check("full_ls_ready", 64'(bus.ls_ready), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 4'd11, 32'h20b);
    tick();
    check("full_third_held", 64'(ls_acc), 64'd0);
    for (int i = 0; i < 4 && !ls_acc; i++) tick();
    check("full_third_accepted", 64'(ls_acc), 64'd1);
    drive_idle();
    repeat (6) tick();
    check("full_drained", 64'(exp_q.size()), 64'd0);

    // Single push: broadcast one edge after acceptance, gone the edge after
    drive(1'b1, 4'd3, 32'h11, 1'b0, '0, '0); tick();
    drive_idle(); tick();
    check("single_valid", 64'(bus.cdb_valid), 64'd1);
    check("single_id", 64'(bus.cdb_rob_id), 64'd3);
    check("single_result", 64'(bus.cdb_result), 64'h11);
    check("single_src", 64'(bus.cdb_src), 64'd0);
    tick();
    check("single_low", 64'(bus.cdb_valid), 64'd0);

    // Flush: both FIFOs loaded, misbranch discards them and the offered inputs
    drive(1'b1, 4'd1, 32'ha1, 1'b1, 4'd2, 32'hb2); tick();
    drive(1'b1, 4'd3, 32'ha3, 1'b1, 4'd4, 32'hb4); tick();
    drive(1'b1, 4'd5, 32'ha5, 1'b1, 4'd6, 32'hb6); tick();
    misbranch_flag = 1'b1;
    drive(1'b1, 4'd7, 32'ha7, 1'b1, 4'd8, 32'hb8); tick();
    misbranch_flag = 1'b0;
    check("flush_valid", 64'(bus.cdb_valid), 64'd0);
    check("flush_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("flush_ls_ready", 64'(bus.ls_ready), 64'd1);
    drive_idle();
    repeat (3) tick();

    // Stall with pending entries, then a zero-tag push
    drive(1'b1, 4'd9, 32'hc9, 1'b1, 4'd10, 32'hda); tick();
    drive(1'b1, 4'd12, 32'hcc, 1'b1, 4'd13, 32'hdd); tick();
    rdy = 1'b0;
    repeat (3) tick();
    check("stall_valid_held", 64'(bus.cdb_valid), 64'd1);
    rdy = 1'b1;
    drive_idle();
    repeat (5) tick();
    obs_ids.delete();
    drive(1'b1, 4'd0, 32'hee, 1'b0, '0, '0); tick();
    drive_idle();
    repeat (3) tick();
    zero_seen = 1'b0;
    foreach (obs_ids[i]) if (obs_ids[i] == '0) zero_seen = 1'b1;
    check("zero_tag_dropped", 64'(zero_seen), 64'd0);
    check("zero_tag_no_bcast", 64'(obs_ids.size()), 64'd0);

    // Asynchronous reset in the middle of a broadcast
    drive(1'b1, 4'd14, 32'hef, 1'b1, 4'd15, 32'hf0); tick();
    drive(1'b1, 4'd1, 32'he1, 1'b1, 4'd2, 32'hf2); tick();
    check("pre_reset_valid", 64'(bus.cdb_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("async_rst_rob_id", 64'(bus.cdb_rob_id), 64'd0);
    reset_model();
    drive_idle();
    #2;
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
